// File: rtl/alu_writeback.sv
// Write-back and branch stage behind the 32-bit ALU: owns A, D and PC, resolves
// jumps from the ALU flags and posts data-memory writes with a valid/ready handshake.
module alu_writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid,
  output logic        inReady,
  input  logic        isC,
  input  logic [0:31] imm,
  input  logic [0:31] aluOut,
  input  logic        aluZr,
  input  logic        aluNg,
  input  logic [0:2]  dest,
  input  logic [0:2]  jump,
  output logic [0:31] aReg,
  output logic [0:31] dReg,
  output logic [0:31] pc,
  output logic        flagZr,
  output logic        flagNg,
  output logic        branchTaken,
  output logic        memWrValid,
  input  logic        memWrReady,
  output logic [0:31] memAddr,
  output logic [0:31] memWdata,
  output logic [15:0] retired
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [0:31] r_a;
  logic [0:31] r_d;
  logic [0:31] r_pc;
  logic        r_zr;
  logic        r_ng;
  logic        r_branch;
  logic        r_mem_valid;
  logic [0:31] r_mem_addr;
  logic [0:31] r_mem_wdata;
  logic [15:0] r_retired;

  logic        w_accept;
  logic        w_take;
  logic        w_mem_req;
  logic        w_mem_done;
  logic [0:31] w_pc_inc;

  // Jump condition over {lt, eq, gt}; flags are taken as given even if inconsistent.
  function automatic logic jump_taken(input logic [0:2] j, input logic zr, input logic ng);
    return (j[0] & ng) | (j[1] & zr) | (j[2] & ~ng & ~zr);
  endfunction

  assign inReady    = (r_state == S_IDLE);
  assign w_accept   = inValid & inReady;
  assign w_take     = isC & jump_taken(jump, aluZr, aluNg);
  assign w_mem_req  = w_accept & isC & dest[2];
  assign w_mem_done = (r_state == S_MEM_WAIT) & memWrReady;
  assign w_pc_inc   = r_pc + 32'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; the handshake edge only returns to IDLE, it never accepts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mem_req) w_state_nxt = S_MEM_WAIT;
        else           w_state_nxt = S_IDLE;
      end
      S_MEM_WAIT: begin
        if (memWrReady) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_MEM_WAIT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Architectural registers, flags, branch pulse and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= 32'h0000_0000;
      r_d       <= 32'h0000_0000;
      r_pc      <= 32'h0000_0000;
      r_zr      <= 1'b0;
      r_ng      <= 1'b0;
      r_branch  <= 1'b0;
      r_retired <= 16'h0000;
    end else if (w_accept) begin
      r_retired <= r_retired + 16'd1;
      if (isC) begin
        if (dest[0]) r_a <= aluOut;
        else         r_a <= r_a;
        if (dest[1]) r_d <= aluOut;
        else         r_d <= r_d;
        r_zr <= aluZr;
        r_ng <= aluNg;
        // Jump target is A as it stood before this instruction's write.
        if (w_take) begin
          r_pc     <= r_a;
          r_branch <= 1'b1;
        end else begin
          r_pc     <= w_pc_inc;
          r_branch <= 1'b0;
        end
      end else begin
        r_a      <= imm;
        r_pc     <= w_pc_inc;
        r_branch <= 1'b0;
      end
    end else begin
      r_branch <= 1'b0;
    end
  end

  // Posted memory write request, held stable until the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_wdata <= 32'h0000_0000;
    end else if (w_mem_req) begin
      r_mem_valid <= 1'b1;
      r_mem_addr  <= r_a;
      r_mem_wdata <= aluOut;
    end else if (w_mem_done) begin
      r_mem_valid <= 1'b0;
    end else begin
      r_mem_valid <= r_mem_valid;
    end
  end

  assign aReg        = r_a;
  assign dReg        = r_d;
  assign pc          = r_pc;
  assign flagZr      = r_zr;
  assign flagNg      = r_ng;
  assign branchTaken = r_branch;
  assign memWrValid  = r_mem_valid;
  assign memAddr     = r_mem_addr;
  assign memWdata    = r_mem_wdata;
  assign retired     = r_retired;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed-vector bench for alu_writeback with hand-computed expectations.
module tb_alu_writeback;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic        isC;
  logic [0:31] imm;
  logic [0:31] aluOut;
  logic        aluZr;
  logic        aluNg;
  logic [0:2]  dest;
  logic [0:2]  jump;
  logic [0:31] aReg;
  logic [0:31] dReg;
  logic [0:31] pc;
  logic        flagZr;
  logic        flagNg;
  logic        branchTaken;
  logic        memWrValid;
  logic        memWrReady;
  logic [0:31] memAddr;
  logic [0:31] memWdata;
  logic [15:0] retired;

  int n_vec = 0;
  int n_err = 0;

  alu_writeback dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady), .isC(isC),
    .imm(imm), .aluOut(aluOut), .aluZr(aluZr), .aluNg(aluNg), .dest(dest),
    .jump(jump), .aReg(aReg), .dReg(dReg), .pc(pc), .flagZr(flagZr),
    .flagNg(flagNg), .branchTaken(branchTaken), .memWrValid(memWrValid),
    .memWrReady(memWrReady), .memAddr(memAddr), .memWdata(memWdata),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ldi(input logic [31:0] v);
    inValid = 1'b1; isC = 1'b0; imm = v;
  endtask

  task automatic cins(input logic [31:0] o, input logic z, input logic n,
                      input logic [2:0] d, input logic [2:0] j);
    inValid = 1'b1; isC = 1'b1; aluOut = o; aluZr = z; aluNg = n; dest = d; jump = j;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_a"}, aReg, 32'h0);
    chk({tag, "_d"}, dReg, 32'h0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_flags"}, {30'd0, flagZr, flagNg}, 32'h0);
    chk({tag, "_br"}, {31'd0, branchTaken}, 32'h0);
    chk({tag, "_mv"}, {31'd0, memWrValid}, 32'h0);
    chk({tag, "_maddr"}, memAddr, 32'h0);
    chk({tag, "_mdata"}, memWdata, 32'h0);
    chk({tag, "_ret"}, {16'd0, retired}, 32'h0);
    chk({tag, "_rdy"}, {31'd0, inReady}, 32'h1);
  endtask

  initial begin
    rst_n = 1'b1; inValid = 1'b0; isC = 1'b0; imm = 32'h0; aluOut = 32'h0;
    aluZr = 1'b0; aluNg = 1'b0; dest = 3'b000; jump = 3'b000; memWrReady = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Load-immediate
    ldi(32'h0000_0010);
    tick();
    chk("ldi_a", aReg, 32'h10);
    chk("ldi_pc", pc, 32'h1);
    chk("ldi_ret", {16'd0, retired}, 32'h1);
    chk("ldi_rdy", {31'd0, inReady}, 32'h1);

    // eq jump, writes A; target is old A
    cins(32'h0, 1'b1, 1'b0, 3'b100, 3'b010);
    tick();
    inValid = 1'b0;
    chk("jeq_a", aReg, 32'h0);
    chk("jeq_pc", pc, 32'h10);
    chk("jeq_br", {31'd0, branchTaken}, 32'h1);
    chk("jeq_zr", {31'd0, flagZr}, 32'h1);
    tick();
    chk("jeq_br_pulse", {31'd0, branchTaken}, 32'h0);
    chk("idle_pc", pc, 32'h10);

    // gt jump with negative result: not taken, writes D
    cins(32'hFFFF_FFFB, 1'b0, 1'b1, 3'b010, 3'b001);
    tick();
    chk("jgt_d", dReg, 32'hFFFF_FFFB);
    chk("jgt_pc", pc, 32'h11);
    chk("jgt_ng", {31'd0, flagNg}, 32'h1);
    chk("jgt_zr", {31'd0, flagZr}, 32'h0);
    chk("jgt_br", {31'd0, branchTaken}, 32'h0);

    ldi(32'h0000_0040);
    tick();
    chk("ldi40_pc", pc, 32'h12);
    // lt jump with negative result: taken
    cins(32'hFFFF_FFFB, 1'b0, 1'b1, 3'b000, 3'b100);
    tick();
    chk("jlt_pc", pc, 32'h40);
    chk("jlt_br", {31'd0, branchTaken}, 32'h1);
    chk("jlt_ret", {16'd0, retired}, 32'h5);

    // memWrReady while no write is pending is ignored
    memWrReady = 1'b1;
    ldi(32'h0000_0020);
    tick();
    chk("stray_rdy_mv", {31'd0, memWrValid}, 32'h0);
    chk("ldi20_pc", pc, 32'h41);
    memWrReady = 1'b0;

    // Memory write with a 3-cycle stall; pending LDI must not be accepted
    cins(32'h1234_5678, 1'b0, 1'b0, 3'b001, 3'b000);
    tick();
    ldi(32'h0000_DEAD);
    chk("mw_pc", pc, 32'h42);
    chk("mw_ret", {16'd0, retired}, 32'h7);
    for (int i = 0; i < 3; i++) begin
      chk("mw_valid", {31'd0, memWrValid}, 32'h1);
      chk("mw_addr", memAddr, 32'h20);
      chk("mw_data", memWdata, 32'h1234_5678);
      chk("mw_rdy", {31'd0, inReady}, 32'h0);
      tick();
    end
    chk("mw_hold_a", aReg, 32'h20);
    memWrReady = 1'b1;
    tick();
    memWrReady = 1'b0;
    chk("mw_done_valid", {31'd0, memWrValid}, 32'h0);
    chk("mw_done_rdy", {31'd0, inReady}, 32'h1);
    chk("mw_done_a", aReg, 32'h20);
    chk("mw_done_ret", {16'd0, retired}, 32'h7);
    tick();
    chk("post_mw_a", aReg, 32'h0000_DEAD);
    chk("post_mw_pc", pc, 32'h43);
    chk("post_mw_ret", {16'd0, retired}, 32'h8);

    // PC wrap via unconditional jump to 0xFFFFFFFF
    ldi(32'hFFFF_FFFF);
    tick();
    cins(32'h0, 1'b0, 1'b0, 3'b000, 3'b111);
    tick();
    chk("jmp_pc", pc, 32'hFFFF_FFFF);
    ldi(32'h0000_0005);
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_a", aReg, 32'h5);
    // jump=000 never jumps even with zr set
    cins(32'h0, 1'b1, 1'b0, 3'b000, 3'b000);
    tick();
    chk("nojmp_pc", pc, 32'h1);
    chk("nojmp_br", {31'd0, branchTaken}, 32'h0);

    // Reset during MEM_WAIT
    cins(32'h0000_00AA, 1'b0, 1'b0, 3'b001, 3'b000);
    tick();
    inValid = 1'b0;
    chk("pre_rst_mv", {31'd0, memWrValid}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_mw");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    ldi(32'h0000_0010);
    tick();
    chk("after_rst_a", aReg, 32'h10);
    chk("after_rst_pc", pc, 32'h1);
    chk("after_rst_ret", {16'd0, retired}, 32'h1);
    chk("after_rst_mv", {31'd0, memWrValid}, 32'h0);

    // Retire counter wrap: 65536 accepts from reset
    inValid = 1'b0;
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    ldi(32'h0000_0001);
    for (int i = 0; i < 65535; i++) tick();
    chk("ret_ffff", {16'd0, retired}, 32'h0000_FFFF);
    tick();
    inValid = 1'b0;
    chk("ret_wrap", {16'd0, retired}, 32'h0);
    chk("ret_wrap_pc", pc, 32'h0001_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
